// File: rtl/pond_nd_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pond_nd_ctrl
//   Next-generation pond: a register-file scratchpad serviced by one write
//   accessor and one read accessor. Each accessor walks an ITER-deep loop nest
//   (selectable depth via *_dim) and produces an address and a firing schedule
//   from per-level stride deltas. The read port is registered (1-cycle latency)
//   with a valid strobe; a write and read that fire on the same address in the
//   same cycle forward the incoming write data. tile_en is a clock enable that
//   freezes all state; flush is a synchronous restart that keeps memory.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   tile_en             clock enable (0 freezes counters, memory, done flags)
//   flush               synchronous restart of counters/accessors/done flags
//   data_in             write data
//   wr_* / rd_*         accessor configuration (dim, ranges, address start and
//                       per-level strides, schedule start and per-level strides)
//   data_out            registered read data (holds when valid_out=0)
//   valid_out           data_out carries a fresh read this cycle
//   wr_done, rd_done    sticky loop-nest-complete flags
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// pond_nd_accessor
//   One loop-nest schedule/address generator. Fires when the shared cycle
//   counter matches its current schedule point; on each fire it advances the
//   lowest level whose counter has not reached its range, clearing the levels
//   below it, and adds that level's stride deltas to the offsets. A fire with
//   no level left to advance is the final point and sets the sticky done flag.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   tile_en_i, flush_i  clock enable, synchronous restart
//   cycle_i             shared cycle counter
//   dim_i ..            accessor configuration
//   addr_o              current address (start + offset, mod 2^ADDR_W)
//   fire_o              access happens this cycle
//   done_o              sticky completion flag
// -----------------------------------------------------------------------------
module pond_nd_accessor #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DIM_W   = 2,
   parameter int unsigned ITER    = 3,
   parameter int unsigned CFG_W   = 6,
   parameter int unsigned CYCLE_W = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      tile_en_i,
   input  logic                      flush_i,
   input  logic [CYCLE_W-1:0]        cycle_i,
   input  logic [DIM_W-1:0]          dim_i,
   input  logic [ITER*CFG_W-1:0]     ranges_i,
   input  logic [ADDR_W-1:0]         addr_start_i,
   input  logic [ITER*ADDR_W-1:0]    addr_strides_i,
   input  logic [CYCLE_W-1:0]        sched_start_i,
   input  logic [ITER*CYCLE_W-1:0]   sched_strides_i,
   output logic [ADDR_W-1:0]         addr_o,
   output logic                      fire_o,
   output logic                      done_o
);

   logic [ITER-1:0][CFG_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0]          addr_off_q, addr_off_d;
   logic [CYCLE_W-1:0]         sched_off_q, sched_off_d;
   logic                       done_q, done_d;

   logic [CYCLE_W-1:0]         sched;
   logic                       lvl_found;
   int unsigned                lvl;

   assign addr_o = addr_start_i + addr_off_q;
   assign sched  = sched_start_i + sched_off_q;
   assign fire_o = tile_en_i & ~flush_i & ~done_q & (dim_i != '0) & (cycle_i == sched);
   assign done_o = done_q;

   // Lowest active level whose counter has not yet reached its range.
   always_comb begin
      lvl_found = 1'b0;
      lvl       = 0;
      for (int unsigned i = 0; i < ITER; i++) begin
         if (!lvl_found && (i < 32'(dim_i)) &&
             (cnt_q[i] != ranges_i[i*CFG_W +: CFG_W])) begin
            lvl_found = 1'b1;
            lvl       = i;
         end
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      addr_off_d  = addr_off_q;
      sched_off_d = sched_off_q;
      done_d      = done_q;
      if (flush_i) begin
         cnt_d       = '0;
         addr_off_d  = '0;
         sched_off_d = '0;
         done_d      = 1'b0;
      end else if (fire_o) begin
         if (lvl_found) begin
            for (int unsigned j = 0; j < ITER; j++) begin
               if (j < lvl) begin
                  cnt_d[j] = '0;
               end else if (j == lvl) begin
                  cnt_d[j] = cnt_q[j] + CFG_W'(1);
               end
            end
            // Strides are deltas applied on a level change; wrap gives
            // negative steps for free.
            addr_off_d  = addr_off_q  + addr_strides_i[lvl*ADDR_W +: ADDR_W];
            sched_off_d = sched_off_q + sched_strides_i[lvl*CYCLE_W +: CYCLE_W];
         end else begin
            // Final point of the nest: counters hold, accessor goes idle.
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         addr_off_q  <= '0;
         sched_off_q <= '0;
         done_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         addr_off_q  <= addr_off_d;
         sched_off_q <= sched_off_d;
         done_q      <= done_d;
      end
   end

endmodule

module pond_nd_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ITER       = 3,
   parameter int unsigned CFG_W      = 6,
   parameter int unsigned CYCLE_W    = 16,
   localparam int unsigned ADDR_W    = $clog2(DEPTH),
   localparam int unsigned DIM_W     = $clog2(ITER+1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tile_en,
   input  logic                      flush,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic [DIM_W-1:0]          wr_dim,
   input  logic [ITER*CFG_W-1:0]     wr_ranges,
   input  logic [ADDR_W-1:0]         wr_addr_start,
   input  logic [ITER*ADDR_W-1:0]    wr_addr_strides,
   input  logic [CYCLE_W-1:0]        wr_sched_start,
   input  logic [ITER*CYCLE_W-1:0]   wr_sched_strides,
   input  logic [DIM_W-1:0]          rd_dim,
   input  logic [ITER*CFG_W-1:0]     rd_ranges,
   input  logic [ADDR_W-1:0]         rd_addr_start,
   input  logic [ITER*ADDR_W-1:0]    rd_addr_strides,
   input  logic [CYCLE_W-1:0]        rd_sched_start,
   input  logic [ITER*CYCLE_W-1:0]   rd_sched_strides,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic                      valid_out,
   output logic                      wr_done,
   output logic                      rd_done
);

   logic [CYCLE_W-1:0]    cycle_q, cycle_d;
   logic [ADDR_W-1:0]     wr_addr, rd_addr;
   logic                  wr_fire, rd_fire;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_out_q, valid_out_d;

   always_comb begin
      cycle_d = cycle_q;
      if (flush) begin
         cycle_d = '0;
      end else if (tile_en) begin
         cycle_d = cycle_q + CYCLE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end

   pond_nd_accessor #(
      .ADDR_W  (ADDR_W),
      .DIM_W   (DIM_W),
      .ITER    (ITER),
      .CFG_W   (CFG_W),
      .CYCLE_W (CYCLE_W)
   ) u_wr_acc (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .tile_en_i       (tile_en),
      .flush_i         (flush),
      .cycle_i         (cycle_q),
      .dim_i           (wr_dim),
      .ranges_i        (wr_ranges),
      .addr_start_i    (wr_addr_start),
      .addr_strides_i  (wr_addr_strides),
      .sched_start_i   (wr_sched_start),
      .sched_strides_i (wr_sched_strides),
      .addr_o          (wr_addr),
      .fire_o          (wr_fire),
      .done_o          (wr_done)
   );

   pond_nd_accessor #(
      .ADDR_W  (ADDR_W),
      .DIM_W   (DIM_W),
      .ITER    (ITER),
      .CFG_W   (CFG_W),
      .CYCLE_W (CYCLE_W)
   ) u_rd_acc (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .tile_en_i       (tile_en),
      .flush_i         (flush),
      .cycle_i         (cycle_q),
      .dim_i           (rd_dim),
      .ranges_i        (rd_ranges),
      .addr_start_i    (rd_addr_start),
      .addr_strides_i  (rd_addr_strides),
      .sched_start_i   (rd_sched_start),
      .sched_strides_i (rd_sched_strides),
      .addr_o          (rd_addr),
      .fire_o          (rd_fire),
      .done_o          (rd_done)
   );

   // Scratchpad is deliberately not reset; contents survive flush.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_addr] <= data_in;
      end
   end

   // Registered read port. A same-cycle write to the read address bypasses
   // the array so the read sees the new word.
   always_comb begin
      data_out_d  = data_out_q;
      valid_out_d = rd_fire;
      if (rd_fire) begin
         if (wr_fire && (wr_addr == rd_addr)) begin
            data_out_d = data_in;
         end else begin
            data_out_d = mem_q[rd_addr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
      end else begin
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

endmodule

// File: doc/pond_nd_ctrl.md
Name: pond_nd_ctrl

Overview:
Parametrised next-generation pond. A register-file scratchpad is driven by one write accessor and one read accessor, each with a schedule and address generator. Each accessor has an N-deep loop nest, a selectable depth and configurable widths. New versus the previous pond:
- registered read port with valid_out
- same-cycle write-to-read forwarding
- clock-enable gating instead of a gated clock
- synchronous flush/restart
- sticky done flags

Sits between the tile input and output muxes of the memory tile.

Parameters:
DATA_WIDTH, 16, data word width
DEPTH, 32, scratchpad words; power of 2; ADDR_W = clog2(DEPTH)
ITER, 3, loop-nest depth per accessor (>=1)
CFG_W, 6, width of each range field
CYCLE_W, 16, width of cycle counter and schedule values

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tile_en  in  1  clock enable; 0 freezes all state
flush  in  1  synchronous restart of counters/accessors
data_in  in  DATA_WIDTH  write data
wr_dim  in  clog2(ITER+1)  write loop dimensionality
wr_ranges  in  ITER*CFG_W  per-level extent minus 1
wr_addr_start  in  ADDR_W  write start address
wr_addr_strides  in  ITER*ADDR_W  per-level address delta
wr_sched_start  in  CYCLE_W  first write cycle
wr_sched_strides  in  ITER*CYCLE_W  per-level schedule delta
rd_dim, rd_ranges, rd_addr_start, rd_addr_strides, rd_sched_start, rd_sched_strides  in  same widths as wr_*  read accessor config
data_out  out  DATA_WIDTH  read data, registered
valid_out  out  1  data_out valid this cycle
wr_done  out  1  write loop nest complete (sticky)
rd_done  out  1  read loop nest complete (sticky)

Behaviour:
- Reset (async, rst_n=0) sets:
  - cycle_count=0; all iterator counters=0
  - address/schedule offsets=0; done flags=0
  - data_out=0; valid_out=0
  - Memory is not reset.
- cycle_count increments by 1 per cycle when tile_en=1, wrapping mod 2^CYCLE_W.
- Per accessor (identical logic):
  - addr = start + addr_off mod DEPTH.
  - sched = sched_start + sched_off mod 2^CYCLE_W.
  - fire = tile_en & ~flush & ~done & (dim!=0) & (cycle_count==sched).
  - Level L = lowest i < dim with cnt[i] != range[i].
  - On fire with L found: cnt[L]+=1; cnt[j<L]=0; addr_off+=addr_stride[L]; sched_off+=sched_stride[L].
  - On fire with no L found (final point): done<=1; counters hold.
  - Strides are deltas applied at a level change, not products; negative steps use two's-complement wrap.
  - dim=0: accessor never fires and done stays 0.
- Write: on wr fire, mem[wr addr] <= data_in at the clock edge.
- Read, 1-cycle latency:
  - On rd fire in cycle t, data_out = mem[rd addr] and valid_out=1 in cycle t+1.
  - If wr also fires in cycle t to the same address, data_out = data_in of cycle t (forwarding).
  - valid_out is 0 in every cycle following a non-fire cycle, including tile_en=0 cycles.
  - data_out holds its last value when valid_out=0.
- tile_en=0: no counter, offset, memory or done update.
- flush=1 (synchronous, acts regardless of tile_en):
  - cycle_count, cnt, offsets and done flags -> 0; valid_out -> 0 next cycle.
  - Any coincident fire is suppressed (no write, no read).
  - Memory is retained.
- After done, the accessor is idle until flush or reset, even if cycle_count wraps back to sched.
- Config inputs must be stable while either accessor is active; changes take effect on the next evaluation with no shadowing.

Test Plan:
1. 1D pass-through
   - Stimulus: wr_dim=1, range 3, addr 0 stride 1, sched 2 stride 1; rd_dim=1, range 3, addr 0 stride 1, sched 8 stride 1; data_in=100+cycle.
   - Required: valid_out in cycles 9..12 with data 102,103,104,105; wr_done=1 from cycle 6; rd_done=1 from cycle 12.
2. 2D transpose
   - Stimulus: write 2x2 sequential at cycles 0..3 (addr strides [1,1]). Read dim 2, ranges [1,1], addr strides [2, DEPTH-1], sched 10, strides [1,1].
   - Required: output order mem[0],mem[2],mem[1],mem[3].
3. Forwarding
   - Stimulus: wr and rd both target address 5 at cycle 4, data_in=0xBEEF, mem[5] previously 0x1111.
   - Required: data_out=0xBEEF with valid_out=1 at cycle 5.
4. Enable stall
   - Stimulus: scenario 1 with tile_en=0 for cycles 3..5.
   - Required: all events shift by 3 cycles; 4 writes and 4 reads exactly; no duplicate valid_out.
5. Flush
   - Stimulus: after scenario 1 completes, pulse flush.
   - Required: done flags clear and the stream replays identically from cycle 0. A flush coincident with a write fire leaves that memory word unchanged.
6. Reset mid-stream
   - Stimulus: drop rst_n asynchronously during read of item 2.
   - Required: valid_out, data_out and done flags go to 0 immediately without a clock edge. After release the stream restarts from cycle_count=0.
